// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ready handshake,
// holds the instruction for the decoder and computes the next PC.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  IMemReq,
  output logic [DATA_WIDTH-1:0] IMemAddr,
  input  logic                  IMemReady,
  input  logic [DATA_WIDTH-1:0] IMemData,
  input  logic                  Stall,
  input  logic                  Jump,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Zero,
  input  logic                  JumpReg,
  input  logic [DATA_WIDTH-1:0] JumpRegAddr,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  Retire,
  output logic                  MisalignErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  retire_q, retire_d;
  logic                  misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] branch_offset;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  branch_taken;
  logic                  jr_misaligned;

  assign pc_plus4      = pc_q + DATA_WIDTH'(4);
  assign branch_offset = {{(DATA_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_taken  = (BranchEQ & Zero) | (BranchNE & ~Zero);
  assign jr_misaligned = JumpReg & (JumpRegAddr[1:0] != 2'b00);

  // Jump register beats jump, jump beats a taken branch.
  always_comb begin
    if (JumpReg) begin
      next_pc = {JumpRegAddr[DATA_WIDTH-1:2], 2'b00};
    end else if (Jump) begin
      next_pc = {pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_offset;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    retire_d   = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (IMemReady) begin
          instr_d = IMemData;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!Stall) begin
          pc_d       = next_pc;
          valid_d    = 1'b0;
          retire_d   = 1'b1;
          misalign_d = jr_misaligned;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      retire_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
    end
  end

  assign IMemReq     = (state_q == FETCH);
  assign IMemAddr    = pc_q;
  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign Retire      = retire_q;
  assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: handshake, stall, branch/jump/jr
// next-PC selection, wrap-around and reset during a fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        Stall;
  logic        Jump;
  logic        BranchEQ;
  logic        BranchNE;
  logic        Zero;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Retire;
  logic        MisalignErr;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemReady   (IMemReady),
    .IMemData    (IMemData),
    .Stall       (Stall),
    .Jump        (Jump),
    .BranchEQ    (BranchEQ),
    .BranchNE    (BranchNE),
    .Zero        (Zero),
    .JumpReg     (JumpReg),
    .JumpRegAddr (JumpRegAddr),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .Retire      (Retire),
    .MisalignErr (MisalignErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    Stall       = 1'b0;
    Jump        = 1'b0;
    BranchEQ    = 1'b0;
    BranchNE    = 1'b0;
    Zero        = 1'b0;
    JumpReg     = 1'b0;
    JumpRegAddr = 32'h0;
  endtask

  // From FETCH: memory answers immediately, unit moves to EXEC.
  task automatic fetch(input logic [31:0] word);
    IMemReady = 1'b1;
    IMemData  = word;
    step();
    IMemReady = 1'b0;
    IMemData  = 32'h0;
  endtask

  task automatic jr_to(input logic [31:0] target);
    fetch(32'h0000_0000);
    JumpReg     = 1'b1;
    JumpRegAddr = target;
    step();
    clear_ctrl();
  endtask

  initial begin
    reset     = 1'b1;
    IMemReady = 1'b0;
    IMemData  = 32'h0;
    clear_ctrl();
    step();

    // Reset state
    check("rst_pc", PC, 32'h0040_0000);
    check("rst_instr", Instruction, 32'h0);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_retire", {31'b0, Retire}, 32'd0);
    check("rst_misalign", {31'b0, MisalignErr}, 32'd0);
    check("rst_req", {31'b0, IMemReq}, 32'd0);

    // First fetch after reset release, memory ready at once
    reset     = 1'b0;
    IMemReady = 1'b1;
    IMemData  = 32'h2008_0005;
    #1;
    check("idle_req", {31'b0, IMemReq}, 32'd0);
    step();
    check("first_req", {31'b0, IMemReq}, 32'd1);
    check("first_addr", IMemAddr, 32'h0040_0000);
    step();
    IMemReady = 1'b0;
    check("exec_valid", {31'b0, InstrValid}, 32'd1);
    check("exec_instr", Instruction, 32'h2008_0005);
    check("exec_pc", PC, 32'h0040_0000);
    check("exec_req", {31'b0, IMemReq}, 32'd0);
    step();
    check("seq_addr", IMemAddr, 32'h0040_0004);
    check("seq_retire", {31'b0, Retire}, 32'd1);
    check("seq_valid", {31'b0, InstrValid}, 32'd0);
    step();
    check("retire_once", {31'b0, Retire}, 32'd0);
    check("wait_addr1", IMemAddr, 32'h0040_0004);
    step();
    check("wait_addr2", IMemAddr, 32'h0040_0004);
    step();
    check("wait_req3", {31'b0, IMemReq}, 32'd1);
    check("wait_addr3", IMemAddr, 32'h0040_0004);

    // Delayed response arrives with Stall high (ignored in FETCH), then stall 2 cycles
    Stall = 1'b1;
    fetch(32'h1234_5678);
    check("stall_valid", {31'b0, InstrValid}, 32'd1);
    step();
    step();
    check("stall_pc", PC, 32'h0040_0004);
    check("stall_instr", Instruction, 32'h1234_5678);
    check("stall_retire", {31'b0, Retire}, 32'd0);
    check("stall_req", {31'b0, IMemReq}, 32'd0);
    Stall = 1'b0;
    step();
    check("unstall_pc", PC, 32'h0040_0008);
    check("unstall_retire", {31'b0, Retire}, 32'd1);

    // Aligned jr to 0x0040_0010
    jr_to(32'h0040_0010);
    check("jr_pc", PC, 32'h0040_0010);
    check("jr_misalign", {31'b0, MisalignErr}, 32'd0);

    // beq -1 taken
    fetch(32'h1000_FFFF);
    BranchEQ = 1'b1;
    Zero     = 1'b1;
    step();
    clear_ctrl();
    check("beq_taken", PC, 32'h0040_0010);

    // beq -1 not taken
    fetch(32'h1000_FFFF);
    BranchEQ = 1'b1;
    Zero     = 1'b0;
    step();
    clear_ctrl();
    check("beq_not_taken", PC, 32'h0040_0014);

    // bne +3 taken at 0x0040_0010
    jr_to(32'h0040_0010);
    fetch(32'h1400_0003);
    BranchNE = 1'b1;
    Zero     = 1'b0;
    step();
    clear_ctrl();
    check("bne_taken", PC, 32'h0040_0020);

    // Misaligned jr beats jump and taken branch
    fetch(32'h0C10_0008);
    JumpReg     = 1'b1;
    JumpRegAddr = 32'h0040_0033;
    Jump        = 1'b1;
    BranchEQ    = 1'b1;
    Zero        = 1'b1;
    step();
    clear_ctrl();
    check("jr_prio_pc", PC, 32'h0040_0030);
    check("jr_misalign_pulse", {31'b0, MisalignErr}, 32'd1);
    check("jr_retire_pulse", {31'b0, Retire}, 32'd1);
    step();
    check("misalign_once", {31'b0, MisalignErr}, 32'd0);

    // jal at 0x0040_0000, with a taken branch also asserted
    jr_to(32'h0040_0000);
    fetch(32'h0C10_0008);
    check("jal_pcplus4", PCPlus4, 32'h0040_0004);
    Jump     = 1'b1;
    BranchEQ = 1'b1;
    Zero     = 1'b1;
    step();
    clear_ctrl();
    check("jal_target", PC, 32'h0040_0020);

    // Sequential wrap from the top of the address space
    jr_to(32'hFFFF_FFFC);
    fetch(32'h0000_0000);
    check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    step();
    check("wrap_pc", PC, 32'h0000_0000);

    // Negative branch offset wrapping below zero: 4 + (-8)
    fetch(32'h1000_FFFE);
    BranchEQ = 1'b1;
    Zero     = 1'b1;
    step();
    clear_ctrl();
    check("neg_wrap_pc", PC, 32'hFFFF_FFFC);
    check("neg_wrap_req", {31'b0, IMemReq}, 32'd1);

    // Reset while in FETCH with memory ready on that cycle
    IMemReady = 1'b1;
    IMemData  = 32'hDEAD_BEEF;
    reset     = 1'b1;
    #1;
    check("midrst_valid", {31'b0, InstrValid}, 32'd0);
    check("midrst_pc", PC, 32'h0040_0000);
    check("midrst_retire", {31'b0, Retire}, 32'd0);
    step();
    check("midrst_instr", Instruction, 32'h0);
    check("midrst_req", {31'b0, IMemReq}, 32'd0);
    reset = 1'b0;
    IMemData = 32'h2008_0005;
    #1;
    check("restart_idle", {31'b0, IMemReq}, 32'd0);
    step();
    check("restart_req", {31'b0, IMemReq}, 32'd1);
    check("restart_addr", IMemAddr, 32'h0040_0000);
    step();
    IMemReady = 1'b0;
    check("restart_instr", Instruction, 32'h2008_0005);
    check("restart_valid", {31'b0, InstrValid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
